// File: rtl/mux_scan_pkg.sv
// ============================================================================
// Module   : mux_scan_pkg
// Purpose  : Shared constants and state type for the mux scan controller.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mux_scan_pkg;

   localparam int NUM_CH   = 4;
   localparam int SEL_W    = 2;
   localparam int SETTLE_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/scan_settle_cnt.sv
// ============================================================================
// Module   : scan_settle_cnt
// Purpose  : Loadable down-counter with zero flag that times the settle window.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module scan_settle_cnt
   import mux_scan_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [SETTLE_W-1:0] load_val,
   input  logic                dec,
   output logic                zero
);

   logic [SETTLE_W-1:0] cnt_q;
   logic [SETTLE_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// ============================================================================
// Module   : mux_scan_ctrl
// Purpose  : Steps a 4:1 mux select, samples each channel after a settle
//            window and hands the 4-bit frame downstream on valid/ready.
//            Optional MUX_SCAN_PARITY_EN adds a registered frame_parity output.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int CONTINUOUS    = 0
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic [SEL_W-1:0] sel,
   input  logic             y_in,
   output logic [NUM_CH-1:0] frame,
   output logic             frame_valid,
   input  logic             frame_ready,
   output logic             overrun
`ifdef MUX_SCAN_PARITY_EN
   ,
   output logic             frame_parity
`endif
);

   // Counter is loaded with N-1 so that exactly N cycles are spent in SETTLE.
   localparam int                  SETTLE_LOAD_I = (SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0;
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD   = SETTLE_LOAD_I[SETTLE_W-1:0];
   localparam scan_state_t         FIRST_ST      = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
   localparam logic [SEL_W-1:0]    LAST_SEL      = SEL_W'(NUM_CH - 1);

   scan_state_t       state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [NUM_CH-1:0] buf_q, buf_d;
   logic [NUM_CH-1:0] frame_q, frame_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              overrun_q, overrun_d;
`ifdef MUX_SCAN_PARITY_EN
   logic              parity_q, parity_d;
`endif

   logic cnt_load;
   logic cnt_dec;
   logic cnt_zero;
   logic load_frame;

   scan_settle_cnt u_settle_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (SETTLE_LOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      buf_d      = buf_q;
      frame_d    = frame_q;
      valid_d    = valid_q;
      overrun_d  = overrun_q;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      load_frame = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity_d   = parity_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               sel_d    = '0;
               state_d  = FIRST_ST;
               cnt_load = 1'b1;
            end
         end
         SETTLE: begin
            if (cnt_zero) begin
               state_d = SAMPLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         SAMPLE: begin
            buf_d[sel_q] = y_in;
            if (sel_q != LAST_SEL) begin
               sel_d    = sel_q + 1'b1;
               state_d  = FIRST_ST;
               cnt_load = 1'b1;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!valid_q || frame_ready) begin
               load_frame = 1'b1;
               if (CONTINUOUS != 0) begin
                  sel_d    = '0;
                  state_d  = FIRST_ST;
                  cnt_load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A fresh load wins over the consumer draining the old frame.
      if (load_frame) begin
         frame_d = buf_q;
         valid_d = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
         parity_d = ^buf_q;
`endif
      end else if (frame_ready) begin
         valid_d = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         buf_q     <= '0;
         frame_q   <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         buf_q     <= buf_d;
         frame_q   <= frame_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
`ifdef MUX_SCAN_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign sel         = sel_q;
   assign frame       = frame_q;
   assign frame_valid = valid_q;
   assign overrun     = overrun_q;
`ifdef MUX_SCAN_PARITY_EN
   assign frame_parity = parity_q;
`endif

endmodule

`default_nettype wire
